udma_multi_ch_reg_if: RTL and testbench
=======================================

# udma_multi_ch_reg_if

Parametrised uDMA peripheral configuration interface serving `N_CH` generic DMA channels instead of a fixed RX/TX pair. It sits between the uDMA configuration bus and the per-channel uDMA controllers, and adds:
- per-channel end-of-transfer (EOT) interrupt latching with a global mask and write-1-to-clear (W1C) status
- a saturating EOT counter per channel
- registered reads with a one-wait-state ready handshake

It keeps the 32-bit external peripheral setup register pair.

## Interface
Parameters:
- `N_CH`, 2: channel count, 1..8
- `L2_AWIDTH_NOAL`, 12: L2 address width
- `TRANS_SIZE`, 16: transfer-size width, ≤24

Ports (all per-channel buses are packed `[N_CH-1:0][W-1:0]`):
- `clk_i`  in  1: single clock; all state on rising edge
- `rstn_i`  in  1: reset, asynchronous, active-low
- `cfg_data_i`  in  32: write data
- `cfg_addr_i`  in  6: word address
- `cfg_valid_i`  in  1: request
- `cfg_rwn_i`  in  1: 1 = read, 0 = write
- `cfg_data_o`  out  32: registered read data
- `cfg_ready_o`  out  1: request accepted/completed
- `ch_startaddr_o`  out  N_CH×L2_AWIDTH_NOAL: start address
- `ch_size_o`  out  N_CH×TRANS_SIZE: transfer size
- `ch_continuous_o`  out  N_CH: continuous mode
- `ch_datasize_o`  out  N_CH×2: datasize
- `ch_en_o`  out  N_CH: one-cycle enable pulse
- `ch_clr_o`  out  N_CH: one-cycle clear pulse
- `ch_en_i`  in  N_CH: channel-active status
- `ch_pending_i`  in  N_CH: pending status
- `ch_curr_addr_i`  in  N_CH×L2_AWIDTH_NOAL: current address
- `ch_bytes_left_i`  in  N_CH×TRANS_SIZE: bytes remaining
- `ch_eot_i`  in  N_CH: one-cycle end-of-transfer pulse
- `irq_o`  out  1: registered interrupt
- `external_per_setup_i`  in  32: setup readback from the peripheral
- `external_per_setup_o`  out  32: setup register

## Operation
Address map (word addresses):
- Channel c occupies words 4c..4c+3: SADDR, SIZE, CFG, INTCFG.
- Global registers:
  - 32 SETUP_INSIDE (RO, returns `external_per_setup_i`)
  - 33 SETUP (RW)
  - 34 IRQ_STATUS (W1C, bits `[N_CH-1:0]`)
  - 35 IRQ_MASK (RW, bits `[N_CH-1:0]`)
- Unmapped addresses, and channel words with c ≥ N_CH: writes ignored, reads return 0, still handshaked.

Per-channel registers:
- SADDR: write sets the start address; read returns `ch_curr_addr_i`, zero-extended.
- SIZE: write sets the size; read returns `ch_bytes_left_i`, zero-extended.
- CFG:
  - Write: bit0 continuous, bits[2:1] datasize, bit4 enable pulse, bit5 clear pulse.
  - Read: `{26'h0, pending, en_i, 1'b0, datasize, continuous}`.
- INTCFG:
  - bit0 EOT-irq enable (RW).
  - bits[15:8] EOT count (RO). It increments on each `ch_eot_i`, saturates at 255, and clears to 0 when that channel's status bit is W1C-cleared.

Interrupts:
- A `ch_eot_i[c]` pulse with INTCFG[c].bit0 = 1 sets `IRQ_STATUS[c]`.
- A simultaneous EOT and W1C on the same bit: set wins, and the count becomes 1.
- `irq_o <= |(IRQ_STATUS & IRQ_MASK)`.

Reset values:
- All address, size, continuous, mask, status, count and setup registers are 0.
- Datasize is 2'b10 on every channel.
- `ch_en_o`, `ch_clr_o`, `irq_o`, `cfg_data_o` are 0.
- Assertion of `rstn_i` mid-operation aborts any read response and clears all state immediately.

## Timing
- Writes: `cfg_ready_o` = 1 combinationally in the cycle `cfg_valid_i & ~cfg_rwn_i`; registers update on that edge.
- `ch_en_o` / `ch_clr_o`: high for exactly the one cycle after the write edge, then 0.
- Reads use a two-state FSM:
  - IDLE: on `cfg_valid_i & cfg_rwn_i`, capture read data into `cfg_data_o` → RESP.
  - RESP: `cfg_ready_o` = 1, `cfg_data_o` is valid → IDLE.
  - `cfg_ready_o` = 0 in IDLE for reads, so read latency is exactly 1 wait state.
  - The master holds valid and address until ready. Back-to-back reads give ready every second cycle.
  - A write arriving while in RESP is not accepted until IDLE.
- `cfg_data_o` holds its value outside RESP. It is checked only while ready is high.
- `irq_o`: one cycle after the status/mask change.

## Structure
- Package `udma_multi_ch_reg_pkg` holds:
  - register word offsets (SADDR = 0 … INTCFG = 3, global 32..35)
  - CFG/INTCFG bit positions
  - datasize reset constant 2'b10
  - read FSM enum `{IDLE, RESP}`
- Sub-module `udma_reg_ch`: one channel's storage, pulse generation, EOT counter and status bit. Instantiated N_CH times via generate.
- The top holds address decode, global registers, read mux/FSM and irq reduction.

## Test plan
- Reset: every output at its reset value; CFG of ch1 reads 0x4. → Read issued at cycle 0, ready at cycle 1 with data 0x00000004.
- Write ch2 CFG = 0x13. → `ch_en_o[2]` is a 1-cycle pulse, `ch_continuous_o[2]` = 1, `ch_datasize_o[2]` = 01, no other channel changes.
- Write SADDR ch0 = 0xABC. → `ch_startaddr_o[0]` = 0xABC. With `ch_curr_addr_i[0]` = 0x123, a read returns 0x00000123 after 1 wait state.
- INTCFG ch1 = 1, MASK = 0x2, pulse `ch_eot_i[1]`. → Status 0x2, `irq_o` rises. Write STATUS = 0x2 in the same cycle as a new EOT → status stays 0x2, count = 1.
- 300 EOT pulses on ch0. → INTCFG[15:8] reads 0xFF. W1C → reads 0x00 and `irq_o` falls.
- Access to address 20 with N_CH = 2. → Read returns 0 and write is ignored, both with ready. Assert reset during RESP → ready drops, FSM returns to IDLE.

Source files
------------

// File: rtl/udma_multi_ch_reg_pkg.sv
// Shared constants and types for the multi-channel uDMA configuration interface.
package udma_multi_ch_reg_pkg;

    // Per-channel register offsets inside each 4-word channel window
    localparam logic [1:0] REG_SADDR  = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_CFG    = 2'd2;
    localparam logic [1:0] REG_INTCFG = 2'd3;

    // Global register word addresses
    localparam logic [5:0] ADDR_SETUP_INSIDE = 6'd32;
    localparam logic [5:0] ADDR_SETUP        = 6'd33;
    localparam logic [5:0] ADDR_IRQ_STATUS   = 6'd34;
    localparam logic [5:0] ADDR_IRQ_MASK     = 6'd35;

    // CFG write-side bit positions
    localparam int CFG_CONT_BIT = 0;
    localparam int CFG_DS_LSB   = 1;
    localparam int CFG_EN_BIT   = 4;
    localparam int CFG_CLR_BIT  = 5;

    // INTCFG bit positions
    localparam int INTCFG_IRQ_EN_BIT = 0;

    // Datasize after reset (32-bit transfers)
    localparam logic [1:0] DATASIZE_RST = 2'b10;

    // EOT counter saturation value
    localparam logic [7:0] EOT_CNT_MAX = 8'hFF;

    // Read handshake states
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/udma_reg_ch.sv
// One uDMA channel: configuration storage, enable/clear pulses,
// EOT interrupt status bit and saturating EOT counter.
module udma_reg_ch
    import udma_multi_ch_reg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wr_saddr,
    input  logic                      wr_size,
    input  logic                      wr_cfg,
    input  logic                      wr_intcfg,
    input  logic [L2_AWIDTH_NOAL-1:0] saddr_wdata,
    input  logic [TRANS_SIZE-1:0]     size_wdata,
    input  logic                      cont_wdata,
    input  logic [1:0]                ds_wdata,
    input  logic                      en_wdata,
    input  logic                      clr_wdata,
    input  logic                      irq_en_wdata,
    input  logic                      status_clr,
    input  logic                      eot,
    output logic [L2_AWIDTH_NOAL-1:0] startaddr,
    output logic [TRANS_SIZE-1:0]     size,
    output logic                      continuous,
    output logic [1:0]                datasize,
    output logic                      en_pulse,
    output logic                      clr_pulse,
    output logic                      irq_en,
    output logic [7:0]                eot_cnt,
    output logic                      status
);

    // Configuration registers written through the config bus
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            startaddr  <= '0;
            size       <= '0;
            continuous <= 1'b0;
            datasize   <= DATASIZE_RST;
            irq_en     <= 1'b0;
        end else begin
            if (wr_saddr) begin
                startaddr <= saddr_wdata;
            end
            if (wr_size) begin
                size <= size_wdata;
            end
            if (wr_cfg) begin
                continuous <= cont_wdata;
                datasize   <= ds_wdata;
            end
            if (wr_intcfg) begin
                irq_en <= irq_en_wdata;
            end
        end
    end

    // Enable/clear are single-cycle pulses following the CFG write edge
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_pulse  <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            en_pulse  <= wr_cfg & en_wdata;
            clr_pulse <= wr_cfg & clr_wdata;
        end
    end

    // Status bit and EOT counter; a new EOT beats a same-cycle W1C
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            status  <= 1'b0;
            eot_cnt <= '0;
        end else begin
            if (eot && irq_en) begin
                status <= 1'b1;
            end else if (status_clr) begin
                status <= 1'b0;
            end
            if (status_clr) begin
                eot_cnt <= eot ? 8'd1 : 8'd0;
            end else if (eot && (eot_cnt != EOT_CNT_MAX)) begin
                eot_cnt <= eot_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/udma_multi_ch_reg_if.sv
// uDMA configuration interface for N_CH generic channels: address decode,
// global registers, registered read path with one wait state, irq reduction.
module udma_multi_ch_reg_if
    import udma_multi_ch_reg_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic [31:0]                          cfg_data_i,
    input  logic [5:0]                           cfg_addr_i,
    input  logic                                 cfg_valid_i,
    input  logic                                 cfg_rwn_i,
    output logic [31:0]                          cfg_data_o,
    output logic                                 cfg_ready_o,
    output logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  ch_startaddr_o,
    output logic [N_CH-1:0][TRANS_SIZE-1:0]      ch_size_o,
    output logic [N_CH-1:0]                      ch_continuous_o,
    output logic [N_CH-1:0][1:0]                 ch_datasize_o,
    output logic [N_CH-1:0]                      ch_en_o,
    output logic [N_CH-1:0]                      ch_clr_o,
    input  logic [N_CH-1:0]                      ch_en_i,
    input  logic [N_CH-1:0]                      ch_pending_i,
    input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  ch_curr_addr_i,
    input  logic [N_CH-1:0][TRANS_SIZE-1:0]      ch_bytes_left_i,
    input  logic [N_CH-1:0]                      ch_eot_i,
    output logic                                 irq_o,
    input  logic [31:0]                          external_per_setup_i,
    output logic [31:0]                          external_per_setup_o
);

    rd_state_t         state_reg;
    rd_state_t         state_next;
    logic [2:0]        chan_sel;
    logic [1:0]        reg_sel;
    logic              is_chan;
    logic              wr_en;
    logic              rd_start;
    logic [N_CH-1:0]   irq_status;
    logic [N_CH-1:0]   irq_mask_reg;
    logic [N_CH-1:0]   status_clr;
    logic [31:0]       rd_data;
    logic [N_CH-1:0][31:0] ch_rdata;

    assign chan_sel = cfg_addr_i[4:2];
    assign reg_sel  = cfg_addr_i[1:0];
    assign is_chan  = ~cfg_addr_i[5] && (32'(chan_sel) < N_CH);
    assign wr_en    = (state_reg == IDLE) & cfg_valid_i & ~cfg_rwn_i;
    assign rd_start = (state_reg == IDLE) & cfg_valid_i & cfg_rwn_i;

    assign status_clr = (wr_en && (cfg_addr_i == ADDR_IRQ_STATUS)) ? cfg_data_i[N_CH-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic       sel;
            logic       irq_en;
            logic [7:0] eot_cnt;

            assign sel = wr_en & is_chan & (chan_sel == 3'(gi));

            udma_reg_ch #(
                .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
                .TRANS_SIZE     (TRANS_SIZE)
            ) u_ch (
                .clk_i        (clk_i),
                .rstn_i       (rstn_i),
                .wr_saddr     (sel & (reg_sel == REG_SADDR)),
                .wr_size      (sel & (reg_sel == REG_SIZE)),
                .wr_cfg       (sel & (reg_sel == REG_CFG)),
                .wr_intcfg    (sel & (reg_sel == REG_INTCFG)),
                .saddr_wdata  (cfg_data_i[L2_AWIDTH_NOAL-1:0]),
                .size_wdata   (cfg_data_i[TRANS_SIZE-1:0]),
                .cont_wdata   (cfg_data_i[CFG_CONT_BIT]),
                .ds_wdata     (cfg_data_i[CFG_DS_LSB+1:CFG_DS_LSB]),
                .en_wdata     (cfg_data_i[CFG_EN_BIT]),
                .clr_wdata    (cfg_data_i[CFG_CLR_BIT]),
                .irq_en_wdata (cfg_data_i[INTCFG_IRQ_EN_BIT]),
                .status_clr   (status_clr[gi]),
                .eot          (ch_eot_i[gi]),
                .startaddr    (ch_startaddr_o[gi]),
                .size         (ch_size_o[gi]),
                .continuous   (ch_continuous_o[gi]),
                .datasize     (ch_datasize_o[gi]),
                .en_pulse     (ch_en_o[gi]),
                .clr_pulse    (ch_clr_o[gi]),
                .irq_en       (irq_en),
                .eot_cnt      (eot_cnt),
                .status       (irq_status[gi])
            );

            // Read word of this channel for the currently addressed register
            assign ch_rdata[gi] =
                (reg_sel == REG_SADDR) ? 32'(ch_curr_addr_i[gi]) :
                (reg_sel == REG_SIZE)  ? 32'(ch_bytes_left_i[gi]) :
                (reg_sel == REG_CFG)   ? 32'({ch_pending_i[gi], ch_en_i[gi], 1'b0,
                                              ch_datasize_o[gi], ch_continuous_o[gi]}) :
                                         32'({eot_cnt, 7'd0, irq_en});
        end
    endgenerate

    // Read data mux; unmapped and absent-channel words read as zero
    always_comb begin
        rd_data = '0;
        if (is_chan) begin
            for (int c = 0; c < N_CH; c++) begin
                if (chan_sel == 3'(c)) begin
                    rd_data = ch_rdata[c];
                end
            end
        end else begin
            case (cfg_addr_i)
                ADDR_SETUP_INSIDE: rd_data = external_per_setup_i;
                ADDR_SETUP:        rd_data = external_per_setup_o;
                ADDR_IRQ_STATUS:   rd_data = 32'(irq_status);
                ADDR_IRQ_MASK:     rd_data = 32'(irq_mask_reg);
                default:           rd_data = '0;
            endcase
        end
    end

    // Read FSM next state and ready; writes complete in the request cycle
    always_comb begin
        state_next  = state_reg;
        cfg_ready_o = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg_valid_i) begin
                    if (cfg_rwn_i) begin
                        state_next = RESP;
                    end else begin
                        cfg_ready_o = 1'b1;
                    end
                end
            end
            RESP: begin
                cfg_ready_o = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read data capture; held between responses
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_data_o <= '0;
        end else if (rd_start) begin
            cfg_data_o <= rd_data;
        end
    end

    // Global setup and mask registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            external_per_setup_o <= '0;
            irq_mask_reg         <= '0;
        end else if (wr_en) begin
            if (cfg_addr_i == ADDR_SETUP) begin
                external_per_setup_o <= cfg_data_i;
            end
            if (cfg_addr_i == ADDR_IRQ_MASK) begin
                irq_mask_reg <= cfg_data_i[N_CH-1:0];
            end
        end
    end

    // Registered interrupt from masked status
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(irq_status & irq_mask_reg);
        end
    end

endmodule

// File: tb/tb_udma_multi_ch_reg_if.sv
// Scoreboard bench for udma_multi_ch_reg_if: directed scenarios then random traffic,
// checked against a register-level reference model.
`timescale 1ns/1ps
module tb_udma_multi_ch_reg_if;

    localparam int N_CH = 3;
    localparam int AW   = 12;
    localparam int TS   = 16;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [31:0]              cfg_data_i;
    logic [5:0]               cfg_addr_i;
    logic                     cfg_valid_i;
    logic                     cfg_rwn_i;
    logic [31:0]              cfg_data_o;
    logic                     cfg_ready_o;
    logic [N_CH-1:0][AW-1:0]  ch_startaddr_o;
    logic [N_CH-1:0][TS-1:0]  ch_size_o;
    logic [N_CH-1:0]          ch_continuous_o;
    logic [N_CH-1:0][1:0]     ch_datasize_o;
    logic [N_CH-1:0]          ch_en_o;
    logic [N_CH-1:0]          ch_clr_o;
    logic [N_CH-1:0]          ch_en_i;
    logic [N_CH-1:0]          ch_pending_i;
    logic [N_CH-1:0][AW-1:0]  ch_curr_addr_i;
    logic [N_CH-1:0][TS-1:0]  ch_bytes_left_i;
    logic [N_CH-1:0]          ch_eot_i;
    logic                     irq_o;
    logic [31:0]              ext_setup_i;
    logic [31:0]              ext_setup_o;

    always #5 clk = ~clk;

    udma_multi_ch_reg_if #(
        .N_CH           (N_CH),
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (TS)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .cfg_data_i           (cfg_data_i),
        .cfg_addr_i           (cfg_addr_i),
        .cfg_valid_i          (cfg_valid_i),
        .cfg_rwn_i            (cfg_rwn_i),
        .cfg_data_o           (cfg_data_o),
        .cfg_ready_o          (cfg_ready_o),
        .ch_startaddr_o       (ch_startaddr_o),
        .ch_size_o            (ch_size_o),
        .ch_continuous_o      (ch_continuous_o),
        .ch_datasize_o        (ch_datasize_o),
        .ch_en_o              (ch_en_o),
        .ch_clr_o             (ch_clr_o),
        .ch_en_i              (ch_en_i),
        .ch_pending_i         (ch_pending_i),
        .ch_curr_addr_i       (ch_curr_addr_i),
        .ch_bytes_left_i      (ch_bytes_left_i),
        .ch_eot_i             (ch_eot_i),
        .irq_o                (irq_o),
        .external_per_setup_i (ext_setup_i),
        .external_per_setup_o (ext_setup_o)
    );

    // Reference model state
    logic [AW-1:0]   m_saddr  [N_CH];
    logic [TS-1:0]   m_size   [N_CH];
    logic            m_cont   [N_CH];
    logic [1:0]      m_ds     [N_CH];
    logic            m_irqen  [N_CH];
    int              m_cnt    [N_CH];
    logic [N_CH-1:0] m_status;
    logic [N_CH-1:0] m_mask;
    logic [31:0]     m_setup;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_saddr[c] = '0;
            m_size[c]  = '0;
            m_cont[c]  = 1'b0;
            m_ds[c]    = 2'b10;
            m_irqen[c] = 1'b0;
            m_cnt[c]   = 0;
        end
        m_status = '0;
        m_mask   = '0;
        m_setup  = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int ai = int'(a);
        int c  = ai / 4;
        logic [31:0] r = '0;
        if (ai < 32) begin
            if (c < N_CH) begin
                case (ai % 4)
                    0: r = 32'(ch_curr_addr_i[c]);
                    1: r = 32'(ch_bytes_left_i[c]);
                    2: r = (32'(ch_pending_i[c]) << 5) | (32'(ch_en_i[c]) << 4) |
                           (32'(m_ds[c]) << 1) | 32'(m_cont[c]);
                    default: r = (32'(m_cnt[c]) << 8) | 32'(m_irqen[c]);
                endcase
            end
        end else if (ai == 32) r = ext_setup_i;
        else if (ai == 33) r = m_setup;
        else if (ai == 34) r = 32'(m_status);
        else if (ai == 35) r = 32'(m_mask);
        return r;
    endfunction

    // Apply one clock edge carrying an optional write and EOT pulses
    task automatic model_apply(input logic [5:0] a, input logic [31:0] d, input logic [N_CH-1:0] eotv,
                               output logic [N_CH-1:0] exp_en, output logic [N_CH-1:0] exp_clr);
        int ai = int'(a);
        logic [N_CH-1:0] w1c;
        exp_en  = '0;
        exp_clr = '0;
        w1c = (ai == 34) ? d[N_CH-1:0] : '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w1c[c]) m_cnt[c] = eotv[c] ? 1 : 0;
            else if (eotv[c] && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
            if (eotv[c] && m_irqen[c]) m_status[c] = 1'b1;
            else if (w1c[c]) m_status[c] = 1'b0;
        end
        if (ai < 32 && (ai / 4) < N_CH) begin
            case (ai % 4)
                0: m_saddr[ai/4] = d[AW-1:0];
                1: m_size[ai/4]  = d[TS-1:0];
                2: begin
                    m_cont[ai/4]   = d[0];
                    m_ds[ai/4]     = d[2:1];
                    exp_en[ai/4]   = d[4];
                    exp_clr[ai/4]  = d[5];
                end
                default: m_irqen[ai/4] = d[0];
            endcase
        end else if (ai == 33) m_setup = d;
        else if (ai == 35) m_mask = d[N_CH-1:0];
    endtask

    task automatic check_static_outputs(input string tag);
        logic [N_CH-1:0][AW-1:0] e_sa;
        logic [N_CH-1:0][TS-1:0] e_sz;
        logic [N_CH-1:0]         e_ct;
        logic [N_CH-1:0][1:0]    e_ds;
        for (int c = 0; c < N_CH; c++) begin
            e_sa[c] = m_saddr[c];
            e_sz[c] = m_size[c];
            e_ct[c] = m_cont[c];
            e_ds[c] = m_ds[c];
        end
        check({tag, "_startaddr"}, 64'(ch_startaddr_o), 64'(e_sa));
        check({tag, "_size"}, 64'(ch_size_o), 64'(e_sz));
        check({tag, "_continuous"}, 64'(ch_continuous_o), 64'(e_ct));
        check({tag, "_datasize"}, 64'(ch_datasize_o), 64'(e_ds));
        check({tag, "_setup_o"}, 64'(ext_setup_o), 64'(m_setup));
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [N_CH-1:0] eotv);
        logic [N_CH-1:0] exp_en, exp_clr;
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        ch_eot_i    = eotv;
        @(negedge clk);
        check("wr_ready", 64'(cfg_ready_o), 64'd1);
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b0;
        ch_eot_i    = '0;
        model_apply(a, d, eotv, exp_en, exp_clr);
        $display("wr addr=%0d data=0x%08h eot=%b", a, d, eotv);
        check("en_pulse", 64'(ch_en_o), 64'(exp_en));
        check("clr_pulse", 64'(ch_clr_o), 64'(exp_clr));
        check_static_outputs("wr");
        @(posedge clk);
        #1;
        check("en_pulse_end", 64'(ch_en_o), 64'd0);
        check("clr_pulse_end", 64'(ch_clr_o), 64'd0);
        check("irq", 64'(irq_o), 64'(|(m_status & m_mask)));
    endtask

    task automatic do_read(input logic [5:0] a);
        int waits = 0;
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = a;
        cfg_data_i  = $urandom;
        exp_q.push_back(model_read(a));
        @(negedge clk);
        while (!cfg_ready_o && waits < 4) begin
            waits++;
            @(negedge clk);
        end
        check("rd_wait_states", 64'(waits), 64'd1);
        if (!cfg_ready_o && exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b0;
    endtask

    task automatic eot_pulse(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] dummy_en, dummy_clr;
        ch_eot_i = v;
        @(posedge clk);
        #1;
        ch_eot_i = '0;
        model_apply(6'd63, 32'd0, v, dummy_en, dummy_clr);
        @(posedge clk);
        #1;
        check("irq_eot", 64'(irq_o), 64'(|(m_status & m_mask)));
    endtask

    task automatic randomize_inputs();
        for (int c = 0; c < N_CH; c++) begin
            ch_curr_addr_i[c]  = AW'($urandom);
            ch_bytes_left_i[c] = TS'($urandom);
        end
        ch_en_i      = N_CH'($urandom);
        ch_pending_i = N_CH'($urandom);
        ext_setup_i  = $urandom;
    endtask

    // Monitor: compare every completed read against the queued expectation
    always @(negedge clk) begin
        if (rstn && cfg_valid_i && cfg_rwn_i && cfg_ready_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got response 0x%08h required none", cfg_data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("rd addr=%0d data=0x%08h", cfg_addr_i, cfg_data_o);
                check("rd_data", 64'(cfg_data_o), 64'(e));
            end
        end
    end

    // Watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn            = 1'b0;
        cfg_valid_i     = 1'b0;
        cfg_rwn_i       = 1'b0;
        cfg_addr_i      = '0;
        cfg_data_i      = '0;
        ch_en_i         = '0;
        ch_pending_i    = '0;
        ch_curr_addr_i  = '0;
        ch_bytes_left_i = '0;
        ch_eot_i        = '0;
        ext_setup_i     = 32'h5A5A_0001;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        check_static_outputs("rst");
        check("rst_en", 64'(ch_en_o), 64'd0);
        check("rst_clr", 64'(ch_clr_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_data", 64'(cfg_data_o), 64'd0);
        check("rst_ready", 64'(cfg_ready_o), 64'd0);
        do_read(6'd6);

        // Channel 2 CFG write with enable pulse
        do_write(6'd10, 32'h13, '0);
        do_read(6'd10);

        // SADDR write and current-address readback
        do_write(6'd0, 32'hABC, '0);
        ch_curr_addr_i[0] = 12'h123;
        do_read(6'd0);
        do_read(6'd32);

        // EOT interrupt on channel 1, then simultaneous W1C and EOT
        do_write(6'd7, 32'h1, '0);
        do_write(6'd35, 32'h2, '0);
        eot_pulse(3'b010);
        do_read(6'd34);
        do_write(6'd34, 32'h2, 3'b010);
        do_read(6'd34);
        do_read(6'd7);
        do_write(6'd34, 32'h2, '0);

        // Counter saturation on channel 0
        do_write(6'd3, 32'h1, '0);
        do_write(6'd35, 32'h3, '0);
        for (int i = 0; i < 300; i++) eot_pulse(3'b001);
        do_read(6'd3);
        do_write(6'd34, 32'h1, '0);
        do_read(6'd3);

        // Unmapped channel word
        do_write(6'd20, 32'hFFFF_FFFF, '0);
        do_read(6'd20);
        do_write(6'd33, 32'hCAFE_F00D, '0);
        do_read(6'd33);

        // Reset during read response
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = 6'd33;
        @(posedge clk);
        #1;
        check("resp_ready", 64'(cfg_ready_o), 64'd1);
        rstn = 1'b0;
        #1;
        check("abort_ready", 64'(cfg_ready_o), 64'd0);
        check("abort_data", 64'(cfg_data_o), 64'd0);
        cfg_valid_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_static_outputs("rst2");
        check("rst2_irq", 64'(irq_o), 64'd0);
        do_read(6'd33);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: do_write(6'($urandom_range(0, 40)), $urandom,
                                     ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0);
                4, 5, 6:    do_read(6'($urandom_range(0, 40)));
                7:          eot_pulse(N_CH'($urandom));
                8:          randomize_inputs();
                default:    do_write(6'd34, $urandom, N_CH'($urandom));
            endcase
        end

        repeat (2) @(posedge clk);
        #1;
        check("rd_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
